imm_encoder: RTL and testbench

//  Packs a 32-bit immediate into the RV32I immediate bit-fields of an

---
 rtl/imm_encoder_pkg.sv | 74 +++++++
 rtl/imm_encoder_if.sv | 28 ++
 rtl/imm_encoder_range_chk.sv | 28 ++
 rtl/imm_encoder.sv | 86 ++++++++
 tb/tb_imm_encoder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the RV32I immediate encoder.
//   imm_src_t : immediate format selector (I/S/B/U/J)
//   OPC_*     : RV32I major opcodes, for users building instruction words
//   *_MIN/MAX : representable immediate range per format
//   imm_req_t : request payload carried through the first pipeline stage
//   pack_imm  : scatter an immediate into the format's instruction bit-fields
package imm_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SRC_W = 3;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [SRC_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_U = 3'b010,
    IMM_B = 3'b101,
    IMM_J = 3'b110
  } imm_src_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic signed [XLEN-1:0] IS_MIN = -32'sd2048;
  localparam logic signed [XLEN-1:0] IS_MAX =  32'sd2047;
  localparam logic signed [XLEN-1:0] B_MIN  = -32'sd4096;
  localparam logic signed [XLEN-1:0] B_MAX  =  32'sd4094;
  localparam logic signed [XLEN-1:0] J_MIN  = -32'sd1048576;
  localparam logic signed [XLEN-1:0] J_MAX  =  32'sd1048574;

  // Source kept as raw bits so illegal encodings survive to the packer.
  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  base;
  } imm_req_t;

  // Illegal formats return base untouched.
  function automatic logic [XLEN-1:0] pack_imm(input logic [SRC_W-1:0] src,
                                               input logic [XLEN-1:0]  imm,
                                               input logic [XLEN-1:0]  base);
    logic [XLEN-1:0] w;
    w = base;
    case (src)
      IMM_I: w[31:20] = imm[11:0];
      IMM_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      IMM_B: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      IMM_U: w[31:12] = imm[31:12];
      IMM_J: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      default: w = base;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bus of the immediate encoder.
//   in_*  : request side (valid/ready, format, immediate, base instruction)
//   out_* : response side (valid/ready, packed instruction, error flag)
//   slave : encoder view; master : producer/consumer view
interface imm_encoder_if;
  import imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [SRC_W-1:0] in_imm_src;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_base;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_inst;
  logic             out_err;

  modport slave (
    input  in_valid, in_imm_src, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );

  modport master (
    output in_valid, in_imm_src, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

endinterface

// File: rtl/imm_encoder_range_chk.sv
// Combinational range check: flags immediates that the selected format
// cannot represent, and illegal format encodings.
//   imm     in  32  immediate (two's complement)
//   imm_src in  3   format selector
//   err     out 1   not representable / illegal format
module imm_range_chk
  import imm_pkg::*;
(
  input  logic [XLEN-1:0]  imm,
  input  logic [SRC_W-1:0] imm_src,
  output logic             err
);

  logic signed [XLEN-1:0] simm;
  assign simm = $signed(imm);

  always_comb begin
    err = 1'b1;
    case (imm_src)
      IMM_I, IMM_S: err = (simm < IS_MIN) || (simm > IS_MAX);
      IMM_B:        err = (simm < B_MIN) || (simm > B_MAX) || imm[0];
      IMM_J:        err = (simm < J_MIN) || (simm > J_MAX) || imm[0];
      IMM_U:        err = (imm[11:0] != 12'h000);
      default:      err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// RV32I immediate encoder: packs an immediate into the bit-fields of a base
// instruction. Two-stage valid/ready pipeline (S1: request + range check,
// S2: packed word), latency 2, throughput 1/cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imm_encoder_if.slave request/response bus
//   err_cnt    : saturating count of errored results leaving (only when
//                IMM_ENCODER_ERR_CNT_EN is defined)
module imm_encoder
  import imm_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  imm_encoder_if.slave   bus
`ifdef IMM_ENCODER_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  imm_req_t        s1_req;
  logic            s1_v;
  logic            s1_err;
  logic            s2_v;
  logic [XLEN-1:0] s2_inst;
  logic            s2_err;
  logic            s1_ready;
  logic            s2_ready;
  logic            chk_err;

  imm_range_chk u_chk (
    .imm     (bus.in_imm),
    .imm_src (bus.in_imm_src),
    .err     (chk_err)
  );

  // A stage advances when it is empty or its downstream is taking data.
  assign s2_ready     = !s2_v || bus.out_ready;
  assign s1_ready     = !s1_v || s2_ready;
  assign bus.in_ready = s1_ready;

  // Stage 1: capture request and range-check result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_req <= '0;
      s1_err <= 1'b0;
    end else if (s1_ready) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_req <= '{src: bus.in_imm_src, imm: bus.in_imm, base: bus.in_base};
        s1_err <= chk_err;
      end
    end
  end

  // Stage 2: packed instruction, drives the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_inst <= '0;
      s2_err  <= 1'b0;
    end else if (s2_ready) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_inst <= pack_imm(s1_req.src, s1_req.imm, s1_req.base);
        s2_err  <= s1_err;
      end
    end
  end

  assign bus.out_valid = s2_v;
  assign bus.out_inst  = s2_inst;
  assign bus.out_err   = s2_err;

`ifdef IMM_ENCODER_ERR_CNT_EN
  // Count errored results as they are consumed; holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (s2_v && bus.out_ready && s2_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed requests push expected
// results into a scoreboard; a monitor pops and compares on each handshake.
module tb_imm_encoder;
  import imm_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   n_acc;
  int   exp_errs;

  imm_encoder_if bus ();

`ifdef IMM_ENCODER_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  imm_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef IMM_ENCODER_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: handshake inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_inst", bus.out_inst, e.inst);
        check("out_err", 32'(bus.out_err), 32'(e.err));
        if (e.err) exp_errs++;
        if (e.lat) check("latency", 32'(cyc - e.acc), 32'd2);
      end
    end
  end

  // Present one request and hold it until accepted; returns #1 after the accept edge.
  task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base,
                      input logic [31:0] exp_inst, input logic exp_err, input bit lat);
    bit got;
    exp_t e;
    bus.in_valid   = 1'b1;
    bus.in_imm_src = src;
    bus.in_imm     = imm;
    bus.in_base    = base;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got   = 1'b1;
        e.inst = exp_inst;
        e.err  = exp_err;
        e.lat  = lat;
        e.acc  = cyc;
        sb.push_back(e);
        n_acc++;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    cyc            = 0;
    n_checks       = 0;
    n_pass         = 0;
    n_acc          = 0;
    exp_errs       = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_imm_src = 3'b000;
    bus.in_imm     = 32'h0;
    bus.in_base    = 32'h0;
    bus.out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back-to-back, no stall: latency checked on each.
    send(IMM_I, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0, 1'b1);
    send(IMM_I, 32'h000007FF, 32'h00000013, 32'h7FF00013, 1'b0, 1'b1);
    send(IMM_I, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0, 1'b1);
    send(IMM_I, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1, 1'b1);
    send(IMM_S, 32'h00000008, 32'h00A12023, 32'h00A12423, 1'b0, 1'b1);
    send(IMM_S, 32'h00000800, 32'h00A12023, 32'h80A12023, 1'b1, 1'b1);
    send(IMM_B, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0, 1'b1);
    send(IMM_B, 32'h00000003, 32'h00000063, 32'h00000163, 1'b1, 1'b1);
    send(IMM_B, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 1'b0, 1'b1);
    send(IMM_J, 32'h00000800, 32'h0000006F, 32'h0010006F, 1'b0, 1'b1);
    send(IMM_J, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1, 1'b1);
    send(IMM_J, 32'hFFF00000, 32'h0000006F, 32'h8000006F, 1'b0, 1'b1);
    send(IMM_J, 32'h00000001, 32'h0000006F, 32'h0000006F, 1'b1, 1'b1);
    send(IMM_U, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0, 1'b1);
    send(IMM_U, 32'h12345001, 32'h00000037, 32'h12345037, 1'b1, 1'b1);
    send(3'b011, 32'h00000004, 32'h12345678, 32'h12345678, 1'b1, 1'b1);
    idle();
    drain();

    // Backpressure: four back-to-back requests with the consumer stalled.
    bus.out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        send(IMM_I, 32'h00000001, 32'h00000013, 32'h00100013, 1'b0, 1'b0);
        send(IMM_I, 32'h00000002, 32'h00000013, 32'h00200013, 1'b0, 1'b0);
        send(IMM_I, 32'h00000003, 32'h00000013, 32'h00300013, 1'b0, 1'b0);
        send(IMM_I, 32'h00000004, 32'h00000013, 32'h00400013, 1'b0, 1'b0);
        idle();
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_accepted", 32'(n_acc), 32'd2);
        @(posedge clk); #1;
        check("stall_hold", 32'(n_acc), 32'd2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with both stages full.
    bus.out_ready = 1'b0;
    send(IMM_S, 32'h00000001, 32'h00000023, 32'h000000A3, 1'b0, 1'b0);
    send(IMM_S, 32'h00000002, 32'h00000023, 32'h00000123, 1'b0, 1'b0);
    idle();
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_out_inst", bus.out_inst, 32'h0);
    sb.delete();
    exp_errs = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(IMM_U, 32'hABCDE000, 32'h00000017, 32'hABCDE017, 1'b0, 1'b1);
    idle();
    drain();

`ifdef IMM_ENCODER_ERR_CNT_EN
    send(IMM_B, 32'h00000001, 32'h00000063, 32'h00000063, 1'b1, 1'b1);
    idle();
    drain();
    @(posedge clk);
    #1;
    check("err_cnt", 32'(err_cnt), 32'(exp_errs));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
